// File: rtl/sleep_seq_ctrl.sv
// sleep_seq_ctrl
// Low-power sequencer between the CSR block and the power-domain switch FSMs.
// It accepts a sleep-mode request and runs a 4-phase req/ack handshake with the
// power switch controller. While asleep it qualifies asynchronous wake sources
// through a 2-flop synchroniser, a programmable debounce and a mask. It leaves
// sleep through the same handshake, then waits a per-mode wake latency before
// returning to ACTIVE.
//
// Ports
//   clk          PMU clock
//   rstn         asynchronous active-low reset
//   sleep_req    1-cycle request pulse; sleep_mode is sampled with it
//   sleep_mode   target mode (0 = ACTIVE/no-op, >= NUM_MODES is illegal)
//   wake_src     asynchronous level wake inputs
//   wake_mask    1 = wake source enabled
//   filt_len     debounce length: stable-high cycles minus 1
//   wake_lat     per-mode wake latency, slice m belongs to mode m
//   pwr_req      handshake request to the power controller
//   pwr_mode     mode presented with the request (held until next accepted request)
//   pwr_ack      handshake acknowledge
//   state        FSM state: ACTIVE=0 ENTER=1 SLEEP=2 EXIT=3 WAKING=4
//   wake_cause   sticky captured wake cause
//   cause_clr    pulse: clear wake_cause
//   wake_done    1-cycle pulse on WAKING->ACTIVE
//   mode_err     1-cycle pulse after an illegal request
//   sleep_cycles cycles spent in SLEEP during the last/current episode
module sleep_seq_ctrl #(
  parameter int NUM_WAKE  = 8,
  parameter int NUM_MODES = 6,
  parameter int MODE_W    = 3,
  parameter int TIMER_W   = 16,
  parameter int FILT_W    = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         sleep_req,
  input  logic [MODE_W-1:0]            sleep_mode,
  input  logic [NUM_WAKE-1:0]          wake_src,
  input  logic [NUM_WAKE-1:0]          wake_mask,
  input  logic [FILT_W-1:0]            filt_len,
  input  logic [NUM_MODES*TIMER_W-1:0] wake_lat,
  output logic                         pwr_req,
  output logic [MODE_W-1:0]            pwr_mode,
  input  logic                         pwr_ack,
  output logic [2:0]                   state,
  output logic [NUM_WAKE-1:0]          wake_cause,
  input  logic                         cause_clr,
  output logic                         wake_done,
  output logic                         mode_err,
  output logic [31:0]                  sleep_cycles
);

  typedef enum logic [2:0] {
    ST_ACTIVE = 3'd0,
    ST_ENTER  = 3'd1,
    ST_SLEEP  = 3'd2,
    ST_EXIT   = 3'd3,
    ST_WAKING = 3'd4
  } state_e;

  // One extra bit so that NUM_MODES == 2**MODE_W still compares correctly.
  localparam logic [MODE_W:0] MODE_LIMIT = (MODE_W+1)'(NUM_MODES);
  localparam int              LAT_N      = 2**MODE_W;

  // ---------------------------------------------------------------------------
  // Wake-source qualification
  // ---------------------------------------------------------------------------
  logic [NUM_WAKE-1:0]           sync1_q;
  logic [NUM_WAKE-1:0]           sync2_q;
  logic [NUM_WAKE-1:0]           qual_q;
  logic [NUM_WAKE-1:0][FILT_W:0] cnt_q;
  logic [FILT_W:0]               filt_thr_s;
  logic [NUM_WAKE-1:0]           hit_s;

  assign filt_thr_s = {1'b0, filt_len};
  assign hit_s      = qual_q & wake_mask;

  // Synchroniser plus debounce counters. cnt_q holds the number of earlier
  // consecutive high cycles, so the current high cycle makes cnt_q+1 in total;
  // qual rises once that total reaches filt_len+1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      qual_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= wake_src;
      sync2_q <= sync1_q;
      for (int i = 0; i < NUM_WAKE; i++) begin
        if (sync2_q[i]) begin
          if (cnt_q[i] != {(FILT_W+1){1'b1}}) begin
            cnt_q[i] <= cnt_q[i] + {{FILT_W{1'b0}}, 1'b1};
          end else begin
            cnt_q[i] <= cnt_q[i];
          end
          qual_q[i] <= (cnt_q[i] >= filt_thr_s);
        end else begin
          cnt_q[i]  <= '0;
          qual_q[i] <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Wake latency lookup, padded to a power of two so any mode code indexes it
  // ---------------------------------------------------------------------------
  logic [TIMER_W-1:0] lat_tbl_s [LAT_N];

  for (genvar m = 0; m < LAT_N; m++) begin : g_lat
    if (m < NUM_MODES) begin : g_used
      assign lat_tbl_s[m] = wake_lat[m*TIMER_W +: TIMER_W];
    end else begin : g_unused
      assign lat_tbl_s[m] = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  state_e              state_q,     state_d;
  logic [MODE_W-1:0]   mode_q,      mode_d;
  logic                pending_q,   pending_d;
  logic [TIMER_W-1:0]  timer_q,     timer_d;
  logic [NUM_WAKE-1:0] cause_q,     cause_d;
  logic [31:0]         sleep_cnt_q, sleep_cnt_d;
  logic                mode_err_q,  mode_err_d;
  logic                wake_done_q, wake_done_d;
  logic                pwr_req_q,   pwr_req_d;

  // State and output registers; reset drops pwr_req immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_ACTIVE;
      mode_q      <= '0;
      pending_q   <= 1'b0;
      timer_q     <= '0;
      cause_q     <= '0;
      sleep_cnt_q <= 32'd0;
      mode_err_q  <= 1'b0;
      wake_done_q <= 1'b0;
      pwr_req_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      pending_q   <= pending_d;
      timer_q     <= timer_d;
      cause_q     <= cause_d;
      sleep_cnt_q <= sleep_cnt_d;
      mode_err_q  <= mode_err_d;
      wake_done_q <= wake_done_d;
      pwr_req_q   <= pwr_req_d;
    end
  end

  // Next-state logic. A cause capture in the same cycle as cause_clr keeps
  // only the freshly captured bits, because the clear is applied first.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    pending_d   = pending_q;
    timer_d     = timer_q;
    cause_d     = cause_clr ? '0 : cause_q;
    sleep_cnt_d = sleep_cnt_q;
    mode_err_d  = 1'b0;
    wake_done_d = 1'b0;
    case (state_q)
      ST_ACTIVE: begin
        if (sleep_req) begin
          if (sleep_mode == '0) begin
            state_d = ST_ACTIVE;
          end else if ({1'b0, sleep_mode} >= MODE_LIMIT) begin
            mode_err_d = 1'b1;
          end else begin
            mode_d  = sleep_mode;
            state_d = ST_ENTER;
          end
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ENTER: begin
        // A wake seen while entering is remembered; the handshake completes first.
        if (|hit_s) begin
          pending_d = 1'b1;
          cause_d   = cause_d | hit_s;
        end else begin
          pending_d = pending_q;
        end
        if (pwr_ack) begin
          state_d     = ST_SLEEP;
          sleep_cnt_d = 32'd0;
        end else begin
          state_d = ST_ENTER;
        end
      end
      ST_SLEEP: begin
        if (sleep_cnt_q != 32'hFFFF_FFFF) begin
          sleep_cnt_d = sleep_cnt_q + 32'd1;
        end else begin
          sleep_cnt_d = sleep_cnt_q;
        end
        cause_d = cause_d | hit_s;
        if ((|hit_s) || pending_q) begin
          state_d   = ST_EXIT;
          pending_d = 1'b0;
        end else begin
          state_d = ST_SLEEP;
        end
      end
      ST_EXIT: begin
        if (!pwr_ack) begin
          state_d = ST_WAKING;
          timer_d = lat_tbl_s[mode_q];
        end else begin
          state_d = ST_EXIT;
        end
      end
      ST_WAKING: begin
        if (timer_q == '0) begin
          state_d     = ST_ACTIVE;
          wake_done_d = 1'b1;
        end else begin
          timer_d = timer_q - {{(TIMER_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d   = ST_ACTIVE;
        pending_d = 1'b0;
      end
    endcase
  end

  // Output decode: request is held throughout ENTER and SLEEP.
  always_comb begin
    pwr_req_d = 1'b0;
    case (state_d)
      ST_ENTER: pwr_req_d = 1'b1;
      ST_SLEEP: pwr_req_d = 1'b1;
      default:  pwr_req_d = 1'b0;
    endcase
  end

  assign pwr_req      = pwr_req_q;
  assign pwr_mode     = mode_q;
  assign state        = state_q;
  assign wake_cause   = cause_q;
  assign wake_done    = wake_done_q;
  assign mode_err     = mode_err_q;
  assign sleep_cycles = sleep_cnt_q;

endmodule
